// File: rtl/decoder_2x4_seq.sv
// Sequenced 2-to-4 decoder: each accepted code drives a registered one-hot line for HOLD
// cycles, then forces GAP idle cycles. Define DEC_ERR_EN to add the sticky err/err_clr pair.
module decoder_2x4_seq #(
    parameter int CODE_W = 2,
    parameter int HOLD   = 3,
    parameter int GAP    = 1,
    localparam int OUT_W = 1 << CODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic              valid_in,
`ifdef DEC_ERR_EN
    input  logic              err_clr,
    output logic              err,
`endif
    output logic              ready_out,
    output logic [OUT_W-1:0]  dec_out,
    output logic              dec_valid,
    output logic              busy
);

    if (CODE_W < 1 || CODE_W > 8) begin : g_bad_code_w
        $error("decoder_2x4_seq: CODE_W out of range");
    end
    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("decoder_2x4_seq: HOLD must be 1..255");
    end
    if (GAP < 0 || GAP > 255) begin : g_bad_gap
        $error("decoder_2x4_seq: GAP must be 0..255");
    end

    localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [7:0]         count, count_nx;
    logic [OUT_W-1:0]   dec_nx;
    logic               dec_valid_nx;
    logic               accept;

    assign busy      = (state != ST_IDLE);
    assign ready_out = ~busy;
    assign accept    = valid_in & ready_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            count     <= 8'd0;
            dec_out   <= '0;
            dec_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            dec_out   <= dec_nx;
            dec_valid <= dec_valid_nx;
        end
    end

    // The one-hot register doubles as the latched code for the whole pulse.
    always_comb begin
        state_nx     = state;
        count_nx     = count;
        dec_nx       = dec_out;
        dec_valid_nx = dec_valid;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx     = ST_DRIVE;
                    count_nx     = HOLD_LD;
                    dec_nx       = OUT_W'(1) << code_in;
                    dec_valid_nx = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (count == 8'd0) begin
                    dec_nx       = '0;
                    dec_valid_nx = 1'b0;
                    if (GAP > 0) begin
                        state_nx = ST_GAP;
                        count_nx = GAP_LD;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    count_nx = count - 8'd1;
                end
            end
            ST_GAP: begin
                if (count == 8'd0) begin
                    state_nx = ST_IDLE;
                end else begin
                    count_nx = count - 8'd1;
                end
            end
            default: begin
                state_nx     = ST_IDLE;
                count_nx     = 8'd0;
                dec_nx       = '0;
                dec_valid_nx = 1'b0;
            end
        endcase
    end

`ifdef DEC_ERR_EN
    // A dropped request in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (valid_in && !ready_out) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`endif

endmodule
